// File: rtl/itu656_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : itu656_encoder_pkg
// Description : Shared constants, types and helpers for the BT.656 525-line
//               transmit path (also reused by the capture-side checker).
//               Contents: timing reference code length, field/V-blank line
//               boundaries, blank fill codes, byte-region type, xyz().
// Revision    : 1.0 - initial release
// ============================================================================
package itu656_encoder_pkg;

    // Length of one timing reference code (FF 00 00 XYZ)
    localparam int c_TRS_LEN   = 4;

    // Field bit: F=1 on lines >= c_F_ON and on lines < c_F_OFF
    localparam int c_F_ON      = 266;
    localparam int c_F_OFF     = 4;

    // Vertical blanking: lines < c_V_END1, and c_V_ON <= line < c_V_OFF
    localparam int c_V_END1    = 20;
    localparam int c_V_ON      = 264;
    localparam int c_V_OFF     = 283;

    // Blank codes: chroma position and luma position
    localparam logic [7:0] c_BLANK_C = 8'h80;
    localparam logic [7:0] c_BLANK_Y = 8'h10;

    // Timing reference preamble bytes
    localparam logic [7:0] c_TRS_FF  = 8'hFF;
    localparam logic [7:0] c_TRS_00  = 8'h00;

    // Which part of the line the horizontal counter is in
    typedef enum logic [1:0] {
        RGN_EAV    = 2'd0,
        RGN_FILL   = 2'd1,
        RGN_SAV    = 2'd2,
        RGN_ACTIVE = 2'd3
    } region_t;

    // Fourth byte of a timing reference code, with Hamming protection bits
    function automatic logic [7:0] xyz(input logic f, input logic v, input logic h);
        return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

endpackage : itu656_encoder_pkg
`default_nettype wire

// File: rtl/itu656_timing.sv
`default_nettype none
// ============================================================================
// Module      : itu656_timing
// Description : Horizontal byte counter and line counter for the BT.656
//               encoder, plus decode of F/V bits and the byte region.
// Ports       : i_clk, i_rst       - clock, synchronous active-high reset
//               o_line             - current line, 1..V_LINES
//               o_field, o_vblank  - F and V bits of the current line
//               o_region           - EAV / fill / SAV / active
//               o_code_idx         - byte index 0..3 inside EAV or SAV
//               o_odd              - parity of the byte inside fill/active
//               o_req_next         - request strobe value for the next cycle
// Revision    : 1.0 - initial release
// ============================================================================
module itu656_timing
    import itu656_encoder_pkg::*;
#(
    parameter int H_ACTIVE = 1440,
    parameter int H_BLANK  = 268,
    parameter int V_LINES  = 525
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [9:0]  o_line,
    output logic        o_field,
    output logic        o_vblank,
    output region_t     o_region,
    output logic [1:0]  o_code_idx,
    output logic        o_odd,
    output logic        o_req_next
);

    localparam int c_LINE_LEN  = 2 * c_TRS_LEN + H_BLANK + H_ACTIVE;
    localparam int c_SAV_START = c_TRS_LEN + H_BLANK;
    localparam int c_ACT_START = 2 * c_TRS_LEN + H_BLANK;

    localparam logic [10:0] c_LAST_H   = 11'(c_LINE_LEN - 1);
    localparam logic [10:0] c_FILL_H   = 11'(c_TRS_LEN);
    localparam logic [10:0] c_SAV_H    = 11'(c_SAV_START);
    localparam logic [10:0] c_ACT_H    = 11'(c_ACT_START);
    // Request is registered, so it is decoded one position early: high while
    // hcnt is in [last SAV byte, second-to-last active byte].
    localparam logic [10:0] c_REQ_LO   = 11'(c_ACT_START - 2);
    localparam logic [10:0] c_REQ_HI   = 11'(c_LINE_LEN - 3);
    localparam logic [9:0]  c_LAST_LN  = 10'(V_LINES);

    logic [10:0] r_hcnt;
    logic [9:0]  r_line;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hcnt <= 11'd0;
            r_line <= 10'd1;
        end else if (r_hcnt == c_LAST_H) begin
            r_hcnt <= 11'd0;
            r_line <= (r_line == c_LAST_LN) ? 10'd1 : r_line + 10'd1;
        end else begin
            r_hcnt <= r_hcnt + 11'd1;
        end
    end

    logic w_field;
    logic w_vblank;

    assign w_field  = (r_line >= 10'(c_F_ON)) || (r_line < 10'(c_F_OFF));
    assign w_vblank = (r_line < 10'(c_V_END1)) ||
                      ((r_line >= 10'(c_V_ON)) && (r_line < 10'(c_V_OFF)));

    region_t w_region;

    always_comb begin
        w_region = RGN_ACTIVE;
        if (r_hcnt < c_FILL_H) begin
            w_region = RGN_EAV;
        end else if (r_hcnt < c_SAV_H) begin
            w_region = RGN_FILL;
        end else if (r_hcnt < c_ACT_H) begin
            w_region = RGN_SAV;
        end
    end

    // EAV starts at 0 and fill at 4 (both even); SAV and active start
    // positions depend on H_BLANK, so rebase their index/parity.
    assign o_code_idx = (w_region == RGN_SAV) ? (r_hcnt[1:0] - c_SAV_H[1:0])
                                              : r_hcnt[1:0];
    assign o_odd      = (w_region == RGN_ACTIVE) ? (r_hcnt[0] ^ c_ACT_H[0])
                                                 : r_hcnt[0];
    assign o_req_next = (r_hcnt >= c_REQ_LO) && (r_hcnt <= c_REQ_HI);

    assign o_line   = r_line;
    assign o_field  = w_field;
    assign o_vblank = w_vblank;
    assign o_region = w_region;

endmodule : itu656_timing
`default_nettype wire

// File: rtl/itu656_encoder.sv
`default_nettype none
// ============================================================================
// Module      : itu656_encoder
// Description : ITU-R BT.656 525-line byte stream generator. Inserts EAV/SAV
//               codes and blanking fill, muxes Cb/Y/Cr/Y from a 4:2:2 source,
//               clamps reserved codes 00/FF out of active video and flags
//               source underflow.
// Ports       : iCLK       - 27 MHz byte clock
//               iRST       - synchronous active-high reset
//               iYCbCr     - [15:8] Y, [7:0] chroma (source alternates Cb/Cr)
//               iValid     - source data valid, sampled with iYCbCr
//               oRequest   - read strobe, data expected one cycle later
//               oTD_DATA   - BT.656 byte stream
//               oLine      - current line number 1..525
//               oField     - F bit of the current line
//               oVBlank    - V bit of the current line
//               oUnderflow - sticky, active byte sampled with iValid low
// Revision    : 1.0 - initial release
// ============================================================================
module itu656_encoder
    import itu656_encoder_pkg::*;
#(
    parameter int H_ACTIVE = 1440,
    parameter int H_BLANK  = 268,
    parameter int V_LINES  = 525
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [15:0] iYCbCr,
    input  logic        iValid,
    output logic        oRequest,
    output logic [7:0]  oTD_DATA,
    output logic [9:0]  oLine,
    output logic        oField,
    output logic        oVBlank,
    output logic        oUnderflow
);

    logic [9:0] w_line;
    logic       w_field;
    logic       w_vblank;
    region_t    w_region;
    logic [1:0] w_code_idx;
    logic       w_odd;
    logic       w_req_next;

    itu656_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_BLANK  (H_BLANK),
        .V_LINES  (V_LINES)
    ) u_timing (
        .i_clk      (iCLK),
        .i_rst      (iRST),
        .o_line     (w_line),
        .o_field    (w_field),
        .o_vblank   (w_vblank),
        .o_region   (w_region),
        .o_code_idx (w_code_idx),
        .o_odd      (w_odd),
        .o_req_next (w_req_next)
    );

    logic [7:0] w_sample;
    logic [7:0] w_clamped;
    logic [7:0] w_blank;
    logic [7:0] w_byte;
    logic       w_underrun;

    // Even active positions carry chroma, odd ones carry luma
    assign w_sample   = w_odd ? iYCbCr[15:8] : iYCbCr[7:0];
    assign w_blank    = w_odd ? c_BLANK_Y : c_BLANK_C;
    assign w_underrun = (w_region == RGN_ACTIVE) && !iValid;

    // 00 and FF are reserved for timing reference codes
    always_comb begin
        w_clamped = w_sample;
        if (w_sample == 8'h00) begin
            w_clamped = 8'h01;
        end else if (w_sample == 8'hFF) begin
            w_clamped = 8'hFE;
        end
    end

    always_comb begin
        w_byte = c_BLANK_C;
        case (w_region)
            RGN_EAV, RGN_SAV: begin
                case (w_code_idx)
                    2'd0:    w_byte = c_TRS_FF;
                    2'd3:    w_byte = xyz(w_field, w_vblank, w_region == RGN_EAV);
                    default: w_byte = c_TRS_00;
                endcase
            end
            RGN_FILL: begin
                w_byte = w_blank;
            end
            RGN_ACTIVE: begin
                w_byte = iValid ? w_clamped : w_blank;
            end
            default: begin
                w_byte = c_BLANK_C;
            end
        endcase
    end

    logic [7:0] r_td;
    logic       r_req;
    logic       r_unf;
    logic [9:0] r_line;
    logic       r_field;
    logic       r_vblank;

    // Line status is a one-cycle-delayed copy of the counter, so it changes
    // on the same edge that presents the first EAV byte of the new line.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_td     <= c_BLANK_C;
            r_req    <= 1'b0;
            r_unf    <= 1'b0;
            r_line   <= 10'd1;
            r_field  <= 1'b1;
            r_vblank <= 1'b1;
        end else begin
            r_td     <= w_byte;
            r_req    <= w_req_next;
            r_unf    <= r_unf | w_underrun;
            r_line   <= w_line;
            r_field  <= w_field;
            r_vblank <= w_vblank;
        end
    end

    assign oTD_DATA   = r_td;
    assign oRequest   = r_req;
    assign oUnderflow = r_unf;
    assign oLine      = r_line;
    assign oField     = r_field;
    assign oVBlank    = r_vblank;

endmodule : itu656_encoder
`default_nettype wire
